// File: rtl/addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_pkg                                                         |
// | Shared constants for the addsub32 sequencer: FSM encoding, data    |
// | width and saturation limits.                                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package addsub_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 32'h80000000;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub32.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub32                                                           |
// | 32-bit ripple-carry adder/subtractor; carry-in = sub, B inverted.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module addsub32
    import addsub_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] ans,
    output logic              cout,
    output logic              v
);

    logic [DATA_W-1:0] w_bx;
    logic              w_carry;
    logic              w_c31;

    assign w_bx = b ^ {DATA_W{sub}};

    always_comb begin
        ans     = '0;
        w_c31   = 1'b0;
        w_carry = sub;
        for (int i = 0; i < DATA_W; i++) begin
            ans[i] = a[i] ^ w_bx[i] ^ w_carry;
            if (i == DATA_W - 1) begin
                w_c31 = w_carry;
            end
            w_carry = (a[i] & w_bx[i]) | (w_carry & (a[i] ^ w_bx[i]));
        end
    end

    assign cout = w_carry;
    assign v    = w_c31 ^ w_carry;

endmodule : addsub32
`default_nettype wire

// File: rtl/addsub32_arb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub32_arb_ctrl                                                  |
// | Round-robin arbiter/sequencer sharing one addsub32 among NREQ      |
// | requesters. Optional macro ADDSUB_SAT_EN saturates on overflow.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module addsub32_arb_ctrl
    import addsub_pkg::*;
#(
    parameter  int NREQ          = 2,
    parameter  int SETTLE_CYCLES = 8,
    localparam int IDW           = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]        req_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_ans,
    output logic                   rsp_cout,
    output logic                   rsp_v,
    output logic                   busy,
    output logic [15:0]            op_cnt
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("addsub32_arb_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("addsub32_arb_ctrl: NREQ must be in 2..8");
    end

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDW-1:0]    r_last;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_sub;

    logic              w_gnt_found;
    logic [IDW-1:0]    w_gnt_idx;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_v;
    logic [DATA_W-1:0] w_ans_cap;

    // Two passes: indices above the last grant first, then wrap to the rest.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_found && i > int'(r_last) && req_valid[i]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_found && i <= int'(r_last) && req_valid[i]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && r_state == ST_IDLE && w_gnt_found) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    addsub32 u_addsub32 (
        .a    (r_a),
        .b    (r_b),
        .sub  (r_sub),
        .ans  (w_sum),
        .cout (w_cout),
        .v    (w_v)
    );

`ifdef ADDSUB_SAT_EN
    // Raw sign bit flipped on overflow, so it selects the opposite limit.
    assign w_ans_cap = w_v ? (w_sum[DATA_W-1] ? SAT_POS : SAT_NEG) : w_sum;
`else
    assign w_ans_cap = w_sum;
`endif

    assign busy = (r_state != ST_IDLE);

    // Counter starts at SETTLE_CYCLES so capture lands SETTLE_CYCLES+1 edges after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_last    <= IDW'(NREQ - 1);
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_ans   <= '0;
            rsp_cout  <= 1'b0;
            rsp_v     <= 1'b0;
            op_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_found) begin
                        r_a     <= req_a[DATA_W*w_gnt_idx +: DATA_W];
                        r_b     <= req_b[DATA_W*w_gnt_idx +: DATA_W];
                        r_sub   <= req_sub[w_gnt_idx];
                        r_last  <= w_gnt_idx;
                        r_cnt   <= CNT_W'(SETTLE_CYCLES);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        rsp_ans   <= w_ans_cap;
                        rsp_cout  <= w_cout;
                        rsp_v     <= w_v;
                        rsp_id    <= r_last;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_cnt    <= op_cnt + 16'd1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : addsub32_arb_ctrl
`default_nettype wire

// File: tb/tb_addsub32_arb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_addsub32_arb_ctrl                                               |
// | Directed self-checking bench for addsub32_arb_ctrl (NREQ=2, S=8).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_addsub32_arb_ctrl;

    localparam int S = 8;

`ifdef ADDSUB_SAT_EN
    localparam logic [31:0] EXP_POS_OVF = 32'h7FFFFFFF;
    localparam logic [31:0] EXP_NEG_OVF = 32'h80000000;
`else
    localparam logic [31:0] EXP_POS_OVF = 32'h80000000;
    localparam logic [31:0] EXP_NEG_OVF = 32'h7FFFFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_ans;
    logic        rsp_cout;
    logic        rsp_v;
    logic        busy;
    logic [15:0] op_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub32_arb_ctrl #(.NREQ(2), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ans   (rsp_ans),
        .rsp_cout  (rsp_cout),
        .rsp_v     (rsp_v),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    // Returns the number of edges until rsp_valid is seen, 0 on timeout.
    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_ans, rsp_cout, rsp_v, busy, op_cnt, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b id=%0d ans=%h cout=%b v=%b busy=%b cnt=%0d rdy=%b, required all 0",
                     rsp_valid, rsp_id, rsp_ans, rsp_cout, rsp_v, busy, op_cnt, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b cnt=%0d, required 0 0 0", busy, rsp_valid, op_cnt);
        end
    endtask

    task automatic test_basic_add();
        int n;
        req_a = {32'h0, 32'h00000021};
        req_b = {32'h0, 32'h00000022};
        req_sub = 2'b00;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL basic_req_ready: got %b, required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        wait_rsp(n);
        checks++;
        if (n !== S + 1) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, required %0d", n, S + 1);
        end
        checks++;
        if (rsp_id !== 1'd0 || rsp_ans !== 32'h00000043 || rsp_cout !== 1'b0 || rsp_v !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: id=%0d ans=%h cout=%b v=%b, required 0 00000043 0 0",
                     rsp_id, rsp_ans, rsp_cout, rsp_v);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || op_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_handshake: valid=%b cnt=%0d busy=%b, required 0 1 0", rsp_valid, op_cnt, busy);
        end
    endtask

    task automatic test_arb_pair();
        int n;
        do_reset();
        req_a = {32'h336FB7E5, 32'h7FFFFFFF};
        req_b = {32'h336FB7E5, 32'h00000001};
        req_sub = 2'b10;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL arb_first_ready: got %b, required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b10;
        wait_rsp(n);
        checks++;
        if (n == 0 || rsp_id !== 1'd0 || rsp_ans !== EXP_POS_OVF || rsp_v !== 1'b1 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL arb_pos_ovf: n=%0d id=%0d ans=%h v=%b cout=%b, required id 0 ans %h v 1 cout 0",
                     n, rsp_id, rsp_ans, rsp_v, rsp_cout, EXP_POS_OVF);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL arb_bubble: busy=%b ready=%b, required 0 10", busy, req_ready);
        end
        wait_rsp(n);
        req_valid = 2'b00;
        checks++;
        if (n == 0 || rsp_id !== 1'd1 || rsp_ans !== 32'h0 || rsp_cout !== 1'b1 || rsp_v !== 1'b0) begin
            errors++;
            $display("FAIL arb_sub_zero: n=%0d id=%0d ans=%h cout=%b v=%b, required id 1 ans 0 cout 1 v 0",
                     n, rsp_id, rsp_ans, rsp_cout, rsp_v);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int n;
        logic [0:0]  exp_id;
        logic [31:0] exp_ans;
        do_reset();
        req_a = {32'd5, 32'd5};
        req_b = {32'd3, 32'd3};
        req_sub = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id  = (k % 2 == 0) ? 1'd0 : 1'd1;
            exp_ans = (k % 2 == 0) ? 32'd8 : 32'd2;
            wait_rsp(n);
            checks++;
            if (n == 0 || rsp_id !== exp_id || rsp_ans !== exp_ans) begin
                errors++;
                $display("FAIL rr_op%0d: n=%0d id=%0d ans=%h, required id %0d ans %h",
                         k, n, rsp_id, rsp_ans, exp_id, exp_ans);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        checks++;
        if (op_cnt !== 16'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_op_cnt: cnt=%0d busy=%b, required 4 0", op_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        req_a = {32'hFFFFFFFF, 32'h0};
        req_b = {32'h00000001, 32'h0};
        req_sub = 2'b00;
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_a = 64'hDEADBEEF_12345678;
        req_b = 64'h0BADF00D_87654321;
        req_sub = 2'b11;
        wait_rsp(n);
        checks++;
        if (n == 0 || rsp_id !== 1'd1 || rsp_ans !== 32'h0 || rsp_cout !== 1'b1 || rsp_v !== 1'b0) begin
            errors++;
            $display("FAIL hold_result: n=%0d id=%0d ans=%h cout=%b v=%b, required id 1 ans 0 cout 1 v 0",
                     n, rsp_id, rsp_ans, rsp_cout, rsp_v);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'd1 || rsp_ans !== 32'h0 || rsp_cout !== 1'b1
                || rsp_v !== 1'b0 || req_ready !== 2'b00 || op_cnt !== 16'd4) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0 (last: valid=%b ans=%h rdy=%b cnt=%0d)",
                     bad, rsp_valid, rsp_ans, req_ready, op_cnt);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        checks++;
        if (op_cnt !== 16'd5 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: cnt=%0d valid=%b, required 5 0", op_cnt, rsp_valid);
        end
    endtask

    task automatic test_sub_overflow();
        int n;
        req_a = {32'h0, 32'h80000000};
        req_b = {32'h0, 32'h00000001};
        req_sub = 2'b01;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(n);
        checks++;
        if (n !== S + 1 || rsp_id !== 1'd0 || rsp_ans !== EXP_NEG_OVF || rsp_cout !== 1'b1 || rsp_v !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf: n=%0d id=%0d ans=%h cout=%b v=%b, required n %0d id 0 ans %h cout 1 v 1",
                     n, rsp_id, rsp_ans, rsp_cout, rsp_v, S + 1, EXP_NEG_OVF);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int n;
        int bad;
        req_a = {32'd7, 32'd1};
        req_b = {32'd7, 32'd1};
        req_sub = 2'b00;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_ans, rsp_cout, rsp_v, busy, op_cnt, req_ready} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%b id=%0d ans=%h busy=%b cnt=%0d rdy=%b, required all 0",
                     rsp_valid, rsp_id, rsp_ans, busy, op_cnt, req_ready);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_no_rsp: %0d cycles with activity, required 0", bad);
        end
        req_a = {32'd7, 32'd1};
        req_b = {32'd7, 32'd1};
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_grant: ready=%b, required 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(n);
        checks++;
        if (n == 0 || rsp_id !== 1'd0 || rsp_ans !== 32'd2) begin
            errors++;
            $display("FAIL midrst_next_op: n=%0d id=%0d ans=%h, required id 0 ans 00000002", n, rsp_id, rsp_ans);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (op_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midrst_op_cnt: got %0d, required 1", op_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_sub   = 2'b00;
        rsp_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_arb_pair();
        test_round_robin();
        test_backpressure();
        test_sub_overflow();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_addsub32_arb_ctrl
`default_nettype wire
